avalon_pio_out_blink: RTL and testbench
=======================================

// Module: avalon_pio_out_blink
// PURPOSE
//  Parametrised Avalon-MM output PIO, successor to the fixed 18-bit LED port.
//  Adds a configurable width, atomic set/clear registers and per-bit hardware
//  blink driven by a programmable prescaler. Sits on the Nios system
//  interconnect as an s1 slave. out_port drives LEDs or other board outputs.
// PARAMETERS
//  DATA_WIDTH      18   width of out_port and data/mask registers (1..32)
//  RESET_VALUE     0    DATA register value after reset
//  PRESCALE_WIDTH  24   width of PERIOD register and prescaler counter (1..32)
//  PERIOD_RESET    0    PERIOD register value after reset (0 = blink frozen)
// PORTS
//  clk         in   1            system clock
//  reset       in   1            synchronous, active-high reset
//  address     in   3            word address of register
//  chipselect  in   1            slave select
//  write_n     in   1            active-low write strobe (qualified by chipselect)
//  writedata   in   32           write data; only low DATA_WIDTH/PRESCALE_WIDTH bits used
//  readdata    out  32           read data, zero-extended, combinational from address
//  out_port    out  DATA_WIDTH   pin outputs
// BEHAVIOUR
//  Write strobe: wr = chipselect & ~write_n. One register write per cycle.
//  Register map (address):
//   0 DATA    R/W  data <= wd; read returns data
//   1 BLINK   R/W  blink_en <= wd; read returns blink_en
//   2 SET     W    data <= data | wd; read returns 0
//   3 CLEAR   W    data <= data & ~wd; read returns 0
//   4 PERIOD  R/W  period <= wd; cnt <= wd; phase <= 1; read returns period
//   5 STATUS  R    bit0 = phase, bits[PRESCALE_WIDTH:1] = cnt; writes ignored
//   6,7       reads return 0; writes ignored
//  Reset (reset=1 at posedge): data=RESET_VALUE, blink_en=0, period=PERIOD_RESET,
//   cnt=PERIOD_RESET, phase=1. So out_port=RESET_VALUE from the first cycle
//   after reset. Reset mid-blink aborts the phase immediately.
//  Prescaler (no write to PERIOD this cycle):
//   period==0 : cnt and phase held; blink frozen with phase=1.
//   cnt!=0    : cnt <= cnt-1.
//   cnt==0    : cnt <= period; phase <= ~phase.
//   Each phase lasts period+1 cycles. Full blink cycle = 2*(period+1) cycles.
//  PERIOD write overrides the prescaler update in the same cycle.
//   Writing the same value also restarts the count.
//  out_port = data & ~(blink_en & {DATA_WIDTH{~phase}}), registered terms only.
//   Bits with blink_en=0 follow data. Bits with blink_en=1 show data while
//   phase=1 and 0 while phase=0.
//  Latency: a register write is visible on out_port and readdata the cycle
//   after the write edge. readdata has zero wait states.
//  SET/CLEAR writes leave blink_en, period, cnt and phase untouched.
//  Upper writedata bits beyond the register width are discarded.
//   readdata upper bits are always 0.
// TESTING
//  1 Reset: hold reset 2 cycles -> out_port=RESET_VALUE, rd addr1=0,
//    rd addr4=PERIOD_RESET, rd addr5 bit0=1.
//  2 DATA/SET/CLEAR: wr0=0x0F0F0; wr2=0x00003; wr3=0x000F0 -> out_port=0x0F003,
//    rd0=0x0F003, rd2=rd3=0.
//  3 Blink: wr0=0x3FFFF, wr1=0x00001, wr4=3 -> out_port bit0 high 4 cycles,
//    low 4 cycles, repeating. Bits 17:1 steady high.
//  4 Period edge: wr4=0 mid-low-phase -> phase=1 next cycle and stays frozen.
//    Then wr4=1 -> bit0 toggles every 2 cycles.
//  5 Reset mid-blink: assert reset while phase=0 -> next cycle out_port=RESET_VALUE,
//    blink_en=0, cnt=PERIOD_RESET.
//  6 Widths: DATA_WIDTH=8, PRESCALE_WIDTH=4; wr0=0xFFFFFFFF, wr4=0xFF ->
//    rd0=0x000000FF, rd4=0x0000000F, out_port=0xFF.

Source files
------------

// File: rtl/avalon_pio_out_blink.sv
// Avalon-MM output PIO with configurable width, atomic set/clear registers
// and per-bit hardware blink driven by a programmable prescaler.
//
// Register map (word address):
//   0 DATA    R/W   output data
//   1 BLINK   R/W   per-bit blink enable
//   2 SET     W     data |= writedata (reads 0)
//   3 CLEAR   W     data &= ~writedata (reads 0)
//   4 PERIOD  R/W   prescaler reload; a write restarts the count with phase=1
//   5 STATUS  R     bit0 = phase, bits[PRESCALE_WIDTH:1] = prescaler count
//   6,7             reserved, read 0, writes ignored
//
// out_port is registered from the next-state values so a write is visible on
// out_port one cycle after the write edge, the same cycle it shows on readdata.
module avalon_pio_out_blink #(
  parameter int unsigned DATA_WIDTH     = 18,
  parameter logic [31:0] RESET_VALUE    = 32'h0000_0000,
  parameter int unsigned PRESCALE_WIDTH = 24,
  parameter logic [31:0] PERIOD_RESET   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_BLINK  = 3'd1;
  localparam logic [2:0] ADDR_SET    = 3'd2;
  localparam logic [2:0] ADDR_CLEAR  = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam logic [DATA_WIDTH-1:0]     DATA_RST   = RESET_VALUE[DATA_WIDTH-1:0];
  localparam logic [PRESCALE_WIDTH-1:0] PERIOD_RST = PERIOD_RESET[PRESCALE_WIDTH-1:0];
  localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE    = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_WIDTH-1:0] CNT_ZERO   = {PRESCALE_WIDTH{1'b0}};

  // Register state
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH-1:0]     blink_en;
  logic [PRESCALE_WIDTH-1:0] period;
  logic [PRESCALE_WIDTH-1:0] cnt;
  logic                      phase;

  // Next-state values
  logic [DATA_WIDTH-1:0]     data_next;
  logic [DATA_WIDTH-1:0]     blink_next;
  logic [PRESCALE_WIDTH-1:0] period_next;
  logic [PRESCALE_WIDTH-1:0] cnt_next;
  logic                      phase_next;
  logic [DATA_WIDTH-1:0]     out_next;

  // Bus decode; upper writedata bits beyond each register width are dropped
  logic                      wr;
  logic                      wr_period;
  logic [DATA_WIDTH-1:0]     wd_data;
  logic [PRESCALE_WIDTH-1:0] wd_period;

  assign wr        = chipselect & ~write_n;
  assign wr_period = wr & (address == ADDR_PERIOD);
  assign wd_data   = writedata[DATA_WIDTH-1:0];
  assign wd_period = writedata[PRESCALE_WIDTH-1:0];

  // Register write decode: DATA/BLINK/SET/CLEAR/PERIOD next values
  always_comb begin
    data_next   = data;
    blink_next  = blink_en;
    period_next = period;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_next   = wd_data;
        ADDR_BLINK:  blink_next  = wd_data;
        ADDR_SET:    data_next   = data | wd_data;
        ADDR_CLEAR:  data_next   = data & ~wd_data;
        ADDR_PERIOD: period_next = wd_period;
        default:     data_next   = data;
      endcase
    end else begin
      data_next   = data;
      blink_next  = blink_en;
      period_next = period;
    end
  end

  // Prescaler: PERIOD write restarts; period 0 freezes; else count down and toggle
  always_comb begin
    cnt_next   = cnt;
    phase_next = phase;
    if (wr_period) begin
      cnt_next   = wd_period;
      phase_next = 1'b1;
    end else if (period == CNT_ZERO) begin
      cnt_next   = cnt;
      phase_next = phase;
    end else if (cnt != CNT_ZERO) begin
      cnt_next   = cnt - CNT_ONE;
      phase_next = phase;
    end else begin
      cnt_next   = period;
      phase_next = ~phase;
    end
  end

  // Output pin value: blinking bits are forced low during the low phase
  always_comb begin
    out_next = data_next & ~(blink_next & {DATA_WIDTH{~phase_next}});
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      data     <= DATA_RST;
      blink_en <= {DATA_WIDTH{1'b0}};
      period   <= PERIOD_RST;
      cnt      <= PERIOD_RST;
      phase    <= 1'b1;
      out_port <= DATA_RST;
    end else begin
      data     <= data_next;
      blink_en <= blink_next;
      period   <= period_next;
      cnt      <= cnt_next;
      phase    <= phase_next;
      out_port <= out_next;
    end
  end

  // Zero-wait-state read mux, zero-extended to 32 bits
  always_comb begin
    readdata = 32'h0000_0000;
    case (address)
      ADDR_DATA:   readdata = 32'(data);
      ADDR_BLINK:  readdata = 32'(blink_en);
      ADDR_PERIOD: readdata = 32'(period);
      ADDR_STATUS: readdata = 32'({cnt, phase});
      default:     readdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_avalon_pio_out_blink.sv
// Self-checking bench for avalon_pio_out_blink. A behavioural model tracks
// registers and elapsed time since the last prescaler restart; phase and count
// are derived from that time with plain division.
module tb_avalon_pio_out_blink;

  localparam int unsigned DW = 18;
  localparam int unsigned PW = 24;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] PR = 32'h0000_0000;
  localparam logic [31:0] DMASK = 32'((64'd1 << DW) - 64'd1);
  localparam logic [31:0] PMASK = 32'((64'd1 << PW) - 64'd1);
  localparam logic [31:0] SMASK = 32'((64'd1 << (PW + 1)) - 64'd1);

  logic          clk;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;

  // narrow instance for the width test
  logic [2:0]    a8;
  logic          cs8;
  logic          wn8;
  logic [31:0]   wd8;
  logic [31:0]   rd8;
  logic [7:0]    out8;

  int total = 0;
  int bad   = 0;

  avalon_pio_out_blink #(
    .DATA_WIDTH(DW), .RESET_VALUE(RV), .PRESCALE_WIDTH(PW), .PERIOD_RESET(PR)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  avalon_pio_out_blink #(
    .DATA_WIDTH(8), .RESET_VALUE(32'h0000_0000), .PRESCALE_WIDTH(4), .PERIOD_RESET(32'h0000_0000)
  ) dut8 (
    .clk(clk), .reset(reset), .address(a8), .chipselect(cs8),
    .write_n(wn8), .writedata(wd8), .readdata(rd8), .out_port(out8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [31:0] m_data;
  logic [31:0] m_blink;
  logic [31:0] m_period;
  longint      m_t;     // cycles since the last prescaler restart

  always @(posedge clk) begin
    if (reset) begin
      m_data   <= RV & DMASK;
      m_blink  <= 32'd0;
      m_period <= PR & PMASK;
      m_t      <= 0;
    end else begin
      m_t <= m_t + 1;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data  <= writedata & DMASK;
          3'd1: m_blink <= writedata & DMASK;
          3'd2: m_data  <= (m_data | writedata) & DMASK;
          3'd3: m_data  <= m_data & ~writedata & DMASK;
          3'd4: begin
            m_period <= writedata & PMASK;
            m_t      <= 0;
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic m_phase();
    longint p;
    p = longint'(m_period);
    if (p == 0) return 1'b1;
    return ((m_t / (p + 1)) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_cnt();
    longint p;
    p = longint'(m_period);
    if (p == 0) return 32'd0;
    return 32'(p - (m_t % (p + 1)));
  endfunction

  function automatic logic [DW-1:0] exp_out();
    logic [31:0] v;
    v = m_data & ~(m_phase() ? 32'd0 : m_blink);
    return v[DW-1:0];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0:    return m_data;
      3'd1:    return m_blink;
      3'd4:    return m_period;
      3'd5:    return ((m_cnt() << 1) | {31'd0, m_phase()}) & SMASK;
      default: return 32'd0;
    endcase
  endfunction

  // Caller is at a negedge; the write lands on the next posedge and the task
  // returns at the following negedge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = $urandom;
  endtask

  // Advance until the model is in the low phase, bounded
  task automatic wait_low_phase(input string name);
    int n;
    n = 0;
    while (m_phase() && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (m_phase()) begin
      total++; bad++;
      $display("FAIL %s: low phase not reached within 40 cycles", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++;
    if (out_port !== RV[DW-1:0]) begin bad++; $display("FAIL reset_out: got %h want %h", out_port, RV[DW-1:0]); end
    address = 3'd1; #1;
    total++;
    if (readdata !== 32'd0) begin bad++; $display("FAIL reset_blink: got %h want 0", readdata); end
    address = 3'd4; #1;
    total++;
    if (readdata !== (PR & PMASK)) begin bad++; $display("FAIL reset_period: got %h want %h", readdata, PR & PMASK); end
    address = 3'd5; #1;
    total++;
    if (readdata[0] !== 1'b1) begin bad++; $display("FAIL reset_phase: got %b want 1", readdata[0]); end
    @(negedge clk);
  endtask

  task automatic test_data_set_clear();
    bus_write(3'd0, 32'h0000_F0F0 | 32'hFFFC_0000);
    bus_write(3'd2, 32'h0000_0003);
    bus_write(3'd3, 32'h0000_00F0);
    total++;
    if (out_port !== 18'h0F003) begin bad++; $display("FAIL dsc_out: got %h want 0f003", out_port); end
    address = 3'd0; #1;
    total++;
    if (readdata !== 32'h0000_F003) begin bad++; $display("FAIL dsc_rd0: got %h want 0000f003", readdata); end
    address = 3'd2; #1;
    total++;
    if (readdata !== 32'd0) begin bad++; $display("FAIL dsc_rd2: got %h want 0", readdata); end
    address = 3'd3; #1;
    total++;
    if (readdata !== 32'd0) begin bad++; $display("FAIL dsc_rd3: got %h want 0", readdata); end
    @(negedge clk);
  endtask

  task automatic test_blink();
    logic expb;
    bus_write(3'd0, 32'h0003_FFFF);
    bus_write(3'd1, 32'h0000_0001);
    bus_write(3'd4, 32'h0000_0003);
    address = 3'd5; #1;
    total++;
    if (readdata !== 32'h0000_0007) begin bad++; $display("FAIL blink_status: got %h want 00000007", readdata); end
    for (int i = 0; i < 16; i++) begin
      expb = ((i / 4) % 2) == 0;
      total++;
      if (out_port[0] !== expb || out_port[17:1] !== 17'h1FFFF || out_port !== exp_out()) begin
        bad++;
        $display("FAIL blink_c%0d: got %h want bit0=%b model=%h", i, out_port, expb, exp_out());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_period_edge();
    logic expb;
    wait_low_phase("period_edge");
    @(negedge clk);  // move into the middle of the low phase
    total++;
    if (out_port[0] !== 1'b0) begin bad++; $display("FAIL pe_low: got %b want 0", out_port[0]); end
    bus_write(3'd4, 32'h0000_0000);
    for (int i = 0; i < 6; i++) begin
      address = 3'd5; #1;
      total++;
      if (out_port[0] !== 1'b1 || readdata !== 32'h0000_0001) begin
        bad++;
        $display("FAIL pe_frozen_c%0d: got bit0=%b status=%h want 1 and 00000001", i, out_port[0], readdata);
      end
      @(negedge clk);
    end
    bus_write(3'd4, 32'h0000_0001);
    for (int i = 0; i < 8; i++) begin
      expb = ((i / 2) % 2) == 0;
      total++;
      if (out_port[0] !== expb || out_port !== exp_out()) begin
        bad++;
        $display("FAIL pe_p1_c%0d: got %h want bit0=%b model=%h", i, out_port, expb, exp_out());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_blink();
    wait_low_phase("reset_mid");
    total++;
    if (out_port[0] !== 1'b0) begin bad++; $display("FAIL rm_low: got %b want 0", out_port[0]); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (out_port !== RV[DW-1:0]) begin bad++; $display("FAIL rm_out: got %h want %h", out_port, RV[DW-1:0]); end
    address = 3'd1; #1;
    total++;
    if (readdata !== 32'd0) begin bad++; $display("FAIL rm_blink: got %h want 0", readdata); end
    address = 3'd5; #1;
    total++;
    if (readdata !== ((((PR & PMASK) << 1) | 32'd1) & SMASK)) begin
      bad++; $display("FAIL rm_status: got %h want %h", readdata, (((PR & PMASK) << 1) | 32'd1) & SMASK);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      chipselect = ($urandom % 4) != 0;
      write_n    = ($urandom % 2) != 0;
      address    = 3'($urandom % 8);
      writedata  = (address == 3'd4) ? $urandom_range(0, 6) : $urandom;
      #1;
      total++;
      if (readdata !== exp_rd(address) || out_port !== exp_out()) begin
        bad++;
        $display("FAIL rand_c%0d: addr=%0d rd=%h want %h out=%h want %h",
                 i, address, readdata, exp_rd(address), out_port, exp_out());
      end
      @(negedge clk);
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_widths();
    a8 = 3'd0; wd8 = 32'hFFFF_FFFF; cs8 = 1'b1; wn8 = 1'b0;
    @(negedge clk);
    a8 = 3'd4; wd8 = 32'h0000_00FF;
    @(negedge clk);
    cs8 = 1'b0; wn8 = 1'b1;
    a8 = 3'd0; #1;
    total++;
    if (rd8 !== 32'h0000_00FF) begin bad++; $display("FAIL w8_rd0: got %h want 000000ff", rd8); end
    a8 = 3'd4; #1;
    total++;
    if (rd8 !== 32'h0000_000F) begin bad++; $display("FAIL w8_rd4: got %h want 0000000f", rd8); end
    total++;
    if (out8 !== 8'hFF) begin bad++; $display("FAIL w8_out: got %h want ff", out8); end
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    a8         = 3'd0;
    cs8        = 1'b0;
    wn8        = 1'b1;
    wd8        = 32'd0;
    @(negedge clk);
    test_reset();
    test_data_set_clear();
    test_blink();
    test_period_edge();
    test_reset_mid_blink();
    test_random();
    test_widths();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
